instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch unit for the rvj1 core: it is the initiator on the single-port synchronous-read instruction memory interface and presents fetched words to the decoder over a valid/ready handshake. It generates sequential word addresses and tracks the memory's fixed one-cycle read latency. A two-entry buffer absorbs decoder back-pressure without losing or duplicating words. A jump request redirects fetch and squashes every word already in flight.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] are treated as 0.
- clk  in  1  single clock; all state updates on rising edge.
- rstn  in  1  asynchronous active-low reset.
- mem_addr  out  32  byte address to the instruction memory; always word-aligned.
- mem_rdata  in  32  memory read data; valid one cycle after the corresponding mem_addr.
- jmp_req  in  1  redirect fetch this cycle.
- jmp_addr  in  32  redirect target; bits [1:0] are ignored and forced to 0.
- instr  out  32  instruction word at the buffer head.
- instr_addr  out  32  byte address of instr.
- instr_valid  out  1  buffer head holds a valid word.
- instr_ready  in  1  decoder accepts instr this cycle.

## Operation
- State:
  - fetch_pc (32): address of the next word to issue; drives mem_addr directly as a register output.
  - rd_pending plus rd_addr: a read was issued last cycle, and its data arrives on mem_rdata this cycle.
  - 2-entry FIFO of {addr, data}, with count 0..2.
- pop = instr_valid & instr_ready.
- issue = !jmp_req & ((count + rd_pending - pop) < 2). When issue is true, fetch_pc <= fetch_pc + 4, rd_pending <= 1, and rd_addr <= fetch_pc. Otherwise rd_pending <= 0.
- Capture: if rd_pending and no jmp_req, push {rd_addr, mem_rdata} into the FIFO this cycle. The credit rule guarantees the FIFO never overflows, so no push is ever dropped for lack of space.
- Push and pop in the same cycle keep count unchanged. FIFO order is strictly the issue order.
- Jump, in the cycle jmp_req = 1:
  - FIFO is cleared and count <= 0.
  - The rd_pending data on mem_rdata is discarded, and rd_pending <= 0.
  - fetch_pc <= {jmp_addr[31:2], 2'b00}.
  - No issue this cycle.
  - A pop in the same cycle still completes; the decoder owns that word.
- Address arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag raised.
- The unit never writes memory. Any memory write-enable is tied 0 at the integration level.

## Timing
- Reset (rstn = 0, asynchronous):
  - fetch_pc = mem_addr = RESET_PC & ~3.
  - rd_pending = 0, count = 0, instr_valid = 0.
  - instr = 0, instr_addr = 0.
- Reset deasserted mid-stream (including mid-jump): all in-flight words are lost. Restart is identical to power-up.
- First edge after reset release: RESET_PC is issued. instr_valid rises after that edge, with instr = mem[RESET_PC].
- Fetch-to-valid latency is 1 cycle, and sustained throughput is 1 word per cycle while instr_ready = 1.
- Jump latency: jmp_req sampled at edge E → mem_addr = target after E → instr_valid with the target word after E+1. instr_valid is 0 for the cycle between E and E+1.
- Back-pressure: with instr_ready = 0, at most 2 words are buffered and mem_addr freezes. When instr_ready returns, words resume one per cycle with no bubble.
- instr and instr_addr are held stable while instr_valid = 1 and instr_ready = 0.
- jmp_req asserted on consecutive cycles: the last jmp_addr wins, and no words are delivered in between.

## Test plan
- Stream after reset, using the bench RAM (word i = i for i = 0..14, word 15 = 32'hFFFF_FFFF) and instr_ready = 1: instr = 0,1,2,…,14 with instr_addr = 0,4,…,0x38 on consecutive cycles, first valid 1 cycle after reset release.
- Back-pressure: drop instr_ready for 3 cycles while instr = 2 is presented. instr must hold 2 and addr 0x8, with mem_addr frozen at 0x10. Resuming then delivers 3, 4, 5, … with no gap, skip or duplicate.
- Jump: jmp_req with jmp_addr = 0x3C while words 4 and 5 are in flight. Words 4 and 5 are never presented, and instr = 32'hFFFF_FFFF with addr 0x3C is valid 2 cycles after jmp_req.
- Misaligned jump plus simultaneous pop: jmp_addr = 0x23 in a handshake cycle. The current word is consumed once, and the next valid word is 8 at addr 0x20.
- Reset mid-stream: assert rstn = 0 asynchronously between edges while 2 words are buffered. instr_valid must drop immediately, and after release the stream restarts at 0 with addr 0.
- Wrap-around with RESET_PC = 32'hFFFF_FFF8, checked on mem_addr only: the sequence is FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues sequential word reads to a one-cycle-latency
// synchronous memory and hands fetched words to the decoder through a 2-entry buffer.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        jmp_req,
  input  logic [31:0] jmp_addr,
  output logic [31:0] instr,
  output logic [31:0] instr_addr,
  output logic        instr_valid,
  input  logic        instr_ready
);

  // Handshake: a word transfers to the decoder on a rising edge where
  // instr_valid & instr_ready; while valid is high and ready is low the
  // head word and its address are held, and valid never drops except on jump/reset.

  localparam logic [31:0] RESET_WORD = RESET_PC & 32'hFFFF_FFFC;

  logic [31:0] fetch_pc;
  logic [31:0] rd_addr;
  logic        rd_pending;
  logic [31:0] q_addr [2];
  logic [31:0] q_data [2];
  logic [1:0]  count;

  logic        pop;
  logic        push;
  logic        issue;
  logic [1:0]  occ;
  logic        head_from_mem;

  logic [31:0] ent_addr [3];
  logic [31:0] ent_data [3];
  logic [1:0]  nxt_count;

  // An in-flight read counts as the logical tail of the buffer, which lets the
  // decoder see a word in the same cycle it arrives from memory.
  assign head_from_mem = (count == 2'd0) & rd_pending;
  assign instr_valid   = (count != 2'd0) | rd_pending;
  assign instr         = head_from_mem ? mem_rdata : q_data[0];
  assign instr_addr    = head_from_mem ? rd_addr   : q_addr[0];
  assign mem_addr      = fetch_pc;

  assign pop   = instr_valid & instr_ready;
  assign push  = rd_pending & ~jmp_req;
  assign occ   = count + {1'b0, rd_pending} - {1'b0, pop};
  assign issue = ~jmp_req & (occ < 2'd2);

  always_comb begin
    ent_addr[0] = q_addr[0];
    ent_addr[1] = q_addr[1];
    ent_addr[2] = rd_addr;
    ent_data[0] = q_data[0];
    ent_data[1] = q_data[1];
    ent_data[2] = mem_rdata;
    nxt_count   = count;
    if (push) begin
      case (count)
        2'd0: begin
          ent_addr[0] = rd_addr;
          ent_data[0] = mem_rdata;
        end
        2'd1: begin
          ent_addr[1] = rd_addr;
          ent_data[1] = mem_rdata;
        end
        default: ;
      endcase
      nxt_count = count + 2'd1;
    end
    if (pop) begin
      ent_addr[0] = ent_addr[1];
      ent_addr[1] = ent_addr[2];
      ent_data[0] = ent_data[1];
      ent_data[1] = ent_data[2];
      nxt_count   = nxt_count - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fetch_pc   <= RESET_WORD;
      rd_addr    <= 32'h0;
      rd_pending <= 1'b0;
      count      <= 2'd0;
      q_addr[0]  <= 32'h0;
      q_addr[1]  <= 32'h0;
      q_data[0]  <= 32'h0;
      q_data[1]  <= 32'h0;
    end else begin
      if (jmp_req) begin
        fetch_pc <= jmp_addr & 32'hFFFF_FFFC;
      end else if (issue) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      rd_pending <= issue;
      if (issue) begin
        rd_addr <= fetch_pc;
      end
      count     <= jmp_req ? 2'd0 : nxt_count;
      q_addr[0] <= ent_addr[0];
      q_addr[1] <= ent_addr[1];
      q_data[0] <= ent_data[0];
      q_data[1] <= ent_data[1];
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: stream, back-pressure, jumps, async
// reset mid-stream and address wrap-around on a second instance.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rstn;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        jmp_req;
  logic [31:0] jmp_addr;
  logic [31:0] instr;
  logic [31:0] instr_addr;
  logic        instr_valid;
  logic        instr_ready;

  logic        w_rstn;
  logic [31:0] w_mem_addr;
  logic [31:0] w_instr;
  logic [31:0] w_instr_addr;
  logic        w_instr_valid;

  logic [31:0] ram [64];
  logic [63:0] exp_q[$];
  logic        sb_on;
  int          n_checks;
  int          n_fail;

  instr_fetch_unit u_dut (
    .clk         (clk),
    .rstn        (rstn),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .jmp_req     (jmp_req),
    .jmp_addr    (jmp_addr),
    .instr       (instr),
    .instr_addr  (instr_addr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk         (clk),
    .rstn        (w_rstn),
    .mem_addr    (w_mem_addr),
    .mem_rdata   (32'h0),
    .jmp_req     (1'b0),
    .jmp_addr    (32'h0),
    .instr       (w_instr),
    .instr_addr  (w_instr_addr),
    .instr_valid (w_instr_valid),
    .instr_ready (1'b1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous-read bench memory, one cycle latency
  always @(posedge clk) mem_rdata <= ram[mem_addr[7:2]];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input string tag, input logic [31:0] a, input logic [31:0] d);
    check({tag, "_valid"}, 64'(instr_valid), 64'd1);
    check({tag, "_instr"}, 64'(instr), 64'(d));
    check({tag, "_addr"}, 64'(instr_addr), 64'(a));
  endtask

  // scoreboard of accepted words, sampled mid-cycle
  always @(negedge clk) begin
    logic [63:0] e;
    if (sb_on && rstn && instr_valid && instr_ready) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
      check("sb_accept", {instr_addr, instr}, e);
    end
  end

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    sb_on       = 1'b0;
    rstn        = 1'b0;
    w_rstn      = 1'b0;
    jmp_req     = 1'b0;
    jmp_addr    = 32'h0;
    instr_ready = 1'b1;
    for (int i = 0; i < 64; i++) ram[i] = 32'(i);
    ram[15] = 32'hFFFF_FFFF;

    // reset state
    tick();
    tick();
    check("rst_mem_addr", 64'(mem_addr), 64'h0);
    check("rst_valid", 64'(instr_valid), 64'd0);
    check("rst_instr", 64'(instr), 64'd0);
    check("rst_instr_addr", 64'(instr_addr), 64'd0);
    check("wrap_rst_addr", 64'(w_mem_addr), 64'hFFFF_FFF8);

    // stream after reset with back-pressure on word 2
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_word("stream", 32'(4 * k), 32'(k));
    end
    instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_word("bp_hold", 32'h8, 32'd2);
      check("bp_mem_addr", 64'(mem_addr), 64'h10);
    end
    instr_ready = 1'b1;
    for (int k = 3; k < 15; k++) begin
      tick();
      expect_word("resume", 32'(4 * k), 32'(k));
    end

    // buffer two words then reset asynchronously between edges
    instr_ready = 1'b0;
    tick();
    tick();
    expect_word("buf2", 32'h38, 32'd14);
    check("buf2_mem_addr", 64'(mem_addr), 64'h40);
    #2;
    rstn = 1'b0;
    #1;
    check("async_rst_valid", 64'(instr_valid), 64'd0);
    check("async_rst_mem_addr", 64'(mem_addr), 64'h0);
    tick();
    tick();
    rstn        = 1'b1;
    instr_ready = 1'b1;
    sb_on       = 1'b1;
    exp_q.push_back({32'h0, 32'd0});
    exp_q.push_back({32'h4, 32'd1});
    exp_q.push_back({32'h8, 32'd2});
    exp_q.push_back({32'hC, 32'd3});
    exp_q.push_back({32'h3C, 32'hFFFF_FFFF});
    exp_q.push_back({32'h40, 32'd16});
    exp_q.push_back({32'h20, 32'd8});
    exp_q.push_back({32'h24, 32'd9});
    for (int k = 0; k < 5; k++) begin
      tick();
      expect_word("restart", 32'(4 * k), 32'(k));
    end

    // jump while words 4 and 5 are in flight and unaccepted
    instr_ready = 1'b0;
    tick();
    expect_word("pre_jmp", 32'h10, 32'd4);
    check("pre_jmp_mem_addr", 64'(mem_addr), 64'h18);
    jmp_req  = 1'b1;
    jmp_addr = 32'h3C;
    tick();
    check("jmp_bubble_valid", 64'(instr_valid), 64'd0);
    check("jmp_mem_addr", 64'(mem_addr), 64'h3C);
    jmp_req     = 1'b0;
    instr_ready = 1'b1;
    tick();
    expect_word("jmp_target", 32'h3C, 32'hFFFF_FFFF);
    tick();
    expect_word("after_jmp", 32'h40, 32'd16);

    // misaligned jump in a handshake cycle
    jmp_req  = 1'b1;
    jmp_addr = 32'h23;
    tick();
    check("mjmp_bubble_valid", 64'(instr_valid), 64'd0);
    check("mjmp_mem_addr", 64'(mem_addr), 64'h20);
    jmp_req = 1'b0;
    tick();
    expect_word("mjmp_target", 32'h20, 32'd8);
    tick();
    expect_word("mjmp_next", 32'h24, 32'd9);

    // back-to-back jumps: last target wins
    jmp_req  = 1'b1;
    jmp_addr = 32'h10;
    tick();
    check("jj_valid_1", 64'(instr_valid), 64'd0);
    jmp_addr = 32'h30;
    tick();
    check("jj_valid_2", 64'(instr_valid), 64'd0);
    check("jj_mem_addr", 64'(mem_addr), 64'h30);
    jmp_req = 1'b0;
    tick();
    expect_word("jj_target", 32'h30, 32'd12);
    sb_on = 1'b0;
    check("sb_left", 64'(exp_q.size()), 64'd0);

    // wrap-around on the second instance
    w_rstn = 1'b1;
    tick();
    check("wrap_1", 64'(w_mem_addr), 64'hFFFF_FFFC);
    tick();
    check("wrap_2", 64'(w_mem_addr), 64'h0000_0000);
    tick();
    check("wrap_3", 64'(w_mem_addr), 64'h0000_0004);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
